// File: rtl/clock_pkg.sv
// clock_pkg: constants and helpers shared by the time/date set path and the
// binary time/date counter.
//   - field widths for the binary counter fields
//   - field limits used by the range check
//   - conversion FSM state encoding
//   - days_in_month(): month length for a binary month and leap flag
package clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int MON_MAX  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_CHECK = 2'd2
    } conv_state_t;

    // Returns 0 for month values outside 1..12 so any day fails the check.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                        input logic leap);
        logic [DAY_W-1:0] d;
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
            4'd2:                                       d = leap ? 5'd29 : 5'd28;
            default:                                    d = 5'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bcd2bin_serial.sv
// bcd2bin_serial: serial reverse double-dabble BCD-to-binary engine.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture bcd_in and restart the conversion
//   bcd_in    - DIGITS packed BCD digits
//   bin_out   - binary result (valid once fin is high)
//   fin       - high after the last shift step, held until the next load
// The working register is {bcd, bin}; each step shifts it right by one and
// then subtracts 3 from every BCD nibble that became >= 8. After 4*DIGITS
// steps the BCD half is empty and the binary half holds the value.
module bcd2bin_serial #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  fin
);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    logic [2*W-1:0]   sr;
    logic [2*W-1:0]   nxt;
    logic [CNT_W-1:0] cnt;

    // Nibble >= 8 is exactly "top bit set".
    always_comb begin
        nxt = sr >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (nxt[W + 4*d + 3])
                nxt[W + 4*d +: 4] = nxt[W + 4*d +: 4] - 4'd3;
        end
    end

    // cnt == W means idle/holding; reset parks it there so nothing shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= CNT_W'(W);
            fin <= 1'b0;
        end else if (load) begin
            sr  <= {bcd_in, {W{1'b0}}};
            cnt <= '0;
            fin <= 1'b0;
        end else if (cnt != CNT_W'(W)) begin
            sr  <= nxt;
            cnt <= cnt + 1'b1;
            fin <= (cnt == CNT_W'(W - 1));
        end
    end

    assign bin_out = sr[W-1:0];

endmodule

// File: rtl/bcd_to_bin_set.sv
// bcd_to_bin_set: converts user-entered BCD time/date digits to the binary
// counter format and range-checks them before they reach the counter load.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start              - conversion request, sampled only in IDLE
//   bcd_ss..bcd_mo     - two-digit BCD fields; bcd_yyyy four-digit BCD year
//   busy               - conversion in progress
//   done               - one-cycle pulse when the result is final
//   err                - last conversion rejected, held until next accepted start
//   sec_bin..year_bin  - binary outputs, only updated by an accepted result
// Handshake: start is a request that is taken only while busy is low; a start
// seen while busy is dropped (no queueing). Each accepted start produces
// exactly one done pulse 18 cycles later unless rst intervenes.
module bcd_to_bin_set
    import clock_pkg::*;
#(
    parameter int YEAR_W   = 12,
    parameter int YEAR_MAX = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        bcd_ss,
    input  logic [7:0]        bcd_mm,
    input  logic [7:0]        bcd_hh,
    input  logic [7:0]        bcd_dd,
    input  logic [7:0]        bcd_mo,
    input  logic [15:0]       bcd_yyyy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SEC_W-1:0]  sec_bin,
    output logic [MIN_W-1:0]  min_bin,
    output logic [HOUR_W-1:0] hour_bin,
    output logic [DAY_W-1:0]  day_bin,
    output logic [MON_W-1:0]  month_bin,
    output logic [YEAR_W-1:0] year_bin
);
    conv_state_t state;
    logic        load;
    logic [15:0] lat_yyyy;
    logic        bad_bcd;

    logic [7:0]  bin_ss, bin_mm, bin_hh, bin_dd, bin_mo;
    logic [15:0] bin_year;
    logic [5:0]  fins;
    logic        conv_fin;

    logic        leap;
    logic        mo_ok;
    logic [DAY_W-1:0] dim;
    logic        result_ok;

    function automatic logic has_bad_nibble(input logic [55:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 14; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // Divisibility by 4 of a BCD pair: 10*t + u == 2*t[0] + u (mod 4).
    function automatic logic div4(input logic [7:0] pair);
        logic [2:0] s;
        s = {1'b0, pair[4], 1'b0} + {1'b0, pair[1:0]};
        return s[1:0] == 2'b00;
    endfunction

    // Engines capture the raw inputs on the same edge the FSM accepts start.
    assign load = (state == ST_IDLE) && start;

    bcd2bin_serial #(.DIGITS(2)) u_ss (.clk(clk), .rst(rst), .load(load), .bcd_in(bcd_ss),   .bin_out(bin_ss),   .fin(fins[0]));
    bcd2bin_serial #(.DIGITS(2)) u_mm (.clk(clk), .rst(rst), .load(load), .bcd_in(bcd_mm),   .bin_out(bin_mm),   .fin(fins[1]));
    bcd2bin_serial #(.DIGITS(2)) u_hh (.clk(clk), .rst(rst), .load(load), .bcd_in(bcd_hh),   .bin_out(bin_hh),   .fin(fins[2]));
    bcd2bin_serial #(.DIGITS(2)) u_dd (.clk(clk), .rst(rst), .load(load), .bcd_in(bcd_dd),   .bin_out(bin_dd),   .fin(fins[3]));
    bcd2bin_serial #(.DIGITS(2)) u_mo (.clk(clk), .rst(rst), .load(load), .bcd_in(bcd_mo),   .bin_out(bin_mo),   .fin(fins[4]));
    bcd2bin_serial #(.DIGITS(4)) u_yr (.clk(clk), .rst(rst), .load(load), .bcd_in(bcd_yyyy), .bin_out(bin_year), .fin(fins[5]));

    // The year engine is the slowest; the AND keeps all engines in step.
    assign conv_fin = &fins;

    // Year 00 suffix: century rule (divisible by 400) reduces to hi % 4.
    assign leap = (lat_yyyy[7:0] == 8'h00) ? div4(lat_yyyy[15:8]) : div4(lat_yyyy[7:0]);

    assign mo_ok = (bin_mo != 8'd0) && (int'(bin_mo) <= MON_MAX);
    assign dim   = days_in_month(mo_ok ? bin_mo[MON_W-1:0] : '0, leap);

    // Checked on full engine widths, before truncation to the port widths.
    assign result_ok = !bad_bcd
                    && (int'(bin_ss) <= SEC_MAX)
                    && (int'(bin_mm) <= MIN_MAX)
                    && (int'(bin_hh) <= HOUR_MAX)
                    && mo_ok
                    && (bin_dd != 8'd0)
                    && (bin_dd <= 8'(dim))
                    && (int'(bin_year) <= YEAR_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            lat_yyyy  <= '0;
            bad_bcd   <= 1'b0;
            sec_bin   <= '0;
            min_bin   <= '0;
            hour_bin  <= '0;
            day_bin   <= DAY_W'(1);
            month_bin <= MON_W'(1);
            year_bin  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_yyyy <= bcd_yyyy;
                        bad_bcd  <= has_bad_nibble({bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy});
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_fin) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (result_ok) begin
                        sec_bin   <= bin_ss[SEC_W-1:0];
                        min_bin   <= bin_mm[MIN_W-1:0];
                        hour_bin  <= bin_hh[HOUR_W-1:0];
                        day_bin   <= bin_dd[DAY_W-1:0];
                        month_bin <= bin_mo[MON_W-1:0];
                        year_bin  <= bin_year[YEAR_W-1:0];
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_set.sv
// Testbench for bcd_to_bin_set: directed cases plus randomized fields,
// checked against a calendar model by a scoreboard/monitor pair.
module tb_bcd_to_bin_set;

  localparam int YW   = 12;
  localparam int YMAX = 4095;
  localparam int EW   = 1 + 6 + 6 + 5 + 5 + 4 + YW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo;
  logic [15:0]   bcd_yyyy;
  logic          busy, done, err;
  logic [5:0]    sec_bin, min_bin;
  logic [4:0]    hour_bin, day_bin;
  logic [3:0]    month_bin;
  logic [YW-1:0] year_bin;

  bcd_to_bin_set #(.YEAR_W(YW), .YEAR_MAX(YMAX)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bcd_ss(bcd_ss), .bcd_mm(bcd_mm), .bcd_hh(bcd_hh), .bcd_dd(bcd_dd),
    .bcd_mo(bcd_mo), .bcd_yyyy(bcd_yyyy),
    .busy(busy), .done(done), .err(err),
    .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
    .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  // model state: the outputs the converter should currently present
  int m_sec, m_min, m_hour, m_day, m_mon, m_year;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_model(input logic e);
    return {e, 6'(m_sec), 6'(m_min), 5'(m_hour), 5'(m_day), 4'(m_mon), YW'(m_year)};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 0;
  endtask

  // Reference: plain calendar arithmetic on decoded digits.
  task automatic model_push(input logic [7:0] ss, mm, hh, dd, mo, input logic [15:0] yy);
    logic [55:0] all;
    logic bad, ok, leap;
    int s, m, h, d, mon, y, dmax;
    int dim_tab[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    all = {ss, mm, hh, dd, mo, yy};
    bad = 1'b0;
    for (int i = 0; i < 14; i++) if (all[4*i +: 4] > 4'd9) bad = 1'b1;
    s   = int'(ss[7:4]) * 10 + int'(ss[3:0]);
    m   = int'(mm[7:4]) * 10 + int'(mm[3:0]);
    h   = int'(hh[7:4]) * 10 + int'(hh[3:0]);
    d   = int'(dd[7:4]) * 10 + int'(dd[3:0]);
    mon = int'(mo[7:4]) * 10 + int'(mo[3:0]);
    y   = int'(yy[15:12]) * 1000 + int'(yy[11:8]) * 100 + int'(yy[7:4]) * 10 + int'(yy[3:0]);
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    ok = !bad && s <= 59 && m <= 59 && h <= 23 && y <= YMAX && mon >= 1 && mon <= 12;
    if (ok) begin
      dmax = (mon == 2 && leap) ? 29 : dim_tab[mon];
      ok = (d >= 1) && (d <= dmax);
    end
    if (ok) begin
      m_sec = s; m_min = m; m_hour = h; m_day = d; m_mon = mon; m_year = y;
    end
    exp_q.push_back(pack_model(!ok));
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // monitor: pops one expectation per done pulse
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_width", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no pending conversion (t=%0t)", $time);
      end else begin
        check("result", {err, sec_bin, min_bin, hour_bin, day_bin, month_bin, year_bin},
              exp_q.pop_front());
      end
    end
    prev_done = rst ? 1'b0 : done;
  end

  // driver tasks
  task automatic set_inputs(input logic [7:0] ss, mm, hh, dd, mo, input logic [15:0] yy);
    bcd_ss = ss; bcd_mm = mm; bcd_hh = hh; bcd_dd = dd; bcd_mo = mo; bcd_yyyy = yy;
  endtask

  // One conversion; poke_at > 0 re-pulses start (with new inputs) at edge N+poke_at.
  task automatic run(input logic [7:0] ss, mm, hh, dd, mo, input logic [15:0] yy, input int poke_at);
    int lat;
    @(negedge clk);
    set_inputs(ss, mm, hh, dd, mo, yy);
    start = 1'b1;
    model_push(ss, mm, hh, dd, mo, yy);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 60) begin
      if (poke_at > 0 && lat == poke_at - 1) begin
        set_inputs(8'h11, 8'h22, 8'h03, 8'h04, 8'h05, 16'h1999);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'd18);
    check("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  // Conversion aborted by rst sampled at edge N+10.
  task automatic run_reset(input logic [7:0] ss, mm, hh, dd, mo, input logic [15:0] yy);
    @(negedge clk);
    set_inputs(ss, mm, hh, dd, mo, yy);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_outputs", {err, sec_bin, min_bin, hour_bin, day_bin, month_bin, year_bin},
          pack_model(1'b0));
    repeat (25) @(negedge clk);
    check("abort_no_done", {63'd0, done}, 64'd0);
  endtask

  // start held for 40 edges: expect done at N+18, N+37 and N+56.
  task automatic run_b2b();
    int dt[3];
    int dcnt;
    @(negedge clk);
    set_inputs(8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 16'h2001);
    start = 1'b1;
    for (int k = 0; k < 3; k++) model_push(8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 16'h2001);
    dcnt = 0;
    dt = '{0, 0, 0};
    for (int l = 0; l <= 60; l++) begin
      @(negedge clk);
      if (done) begin
        if (dcnt < 3) dt[dcnt] = l;
        dcnt++;
      end
      if (l == 39) start = 1'b0;
    end
    check("b2b_done1", 64'(dt[0]), 64'd18);
    check("b2b_done2", 64'(dt[1]), 64'd37);
    check("b2b_count", 64'(dcnt), 64'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_flags", {61'd0, busy, done, err}, 64'd0);
    check("reset_outputs", {err, sec_bin, min_bin, hour_bin, day_bin, month_bin, year_bin},
          pack_model(1'b0));
    rst = 1'b0;

    // main case and leap rules
    run(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h2024, 0);
    run(8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 16'h2000, 0);
    run(8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 16'h1900, 0);
    run(8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 16'h2024, 0);
    run(8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 16'h2023, 0);
    run(8'h00, 8'h00, 8'h00, 8'h30, 8'h02, 16'h2024, 0);
    // bad BCD and limits
    run(8'h1A, 8'h10, 8'h10, 8'h10, 8'h10, 16'h2010, 0);
    run(8'h10, 8'h10, 8'h24, 8'h10, 8'h10, 16'h2010, 0);
    run(8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 16'h2010, 0);
    run(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 16'h4096, 0);
    run(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 16'h4095, 0);
    run(8'h30, 8'h31, 8'h04, 8'h31, 8'h04, 16'h2022, 0);
    // start during busy is ignored
    run(8'h45, 8'h34, 8'h12, 8'h15, 8'h06, 16'h1987, 5);
    // reset mid-conversion, then a normal conversion
    run_reset(8'h45, 8'h34, 8'h12, 8'h15, 8'h06, 16'h1987);
    run(8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 16'h2010, 0);
    // back-to-back
    run_b2b();

    // randomized fields, occasionally out of range or with a bad nibble
    for (int i = 0; i < 40; i++) begin
      logic [7:0] f[5];
      logic [15:0] yy;
      int lim[5] = '{62, 62, 25, 33, 14};
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 9) == 0) f[k] = 8'($urandom_range(0, 255));
        else f[k] = to_bcd2($urandom_range(0, lim[k]));
      end
      if ($urandom_range(0, 3) == 0) f[3] = 8'h29;
      if ($urandom_range(0, 3) == 0) f[4] = 8'h02;
      case ($urandom_range(0, 5))
        0:       yy = 16'($urandom_range(0, 65535));
        1:       yy = to_bcd4($urandom_range(4000, 9999));
        2:       yy = to_bcd4($urandom_range(0, 40) * 100);
        default: yy = to_bcd4($urandom_range(0, 4095));
      endcase
      run(f[0], f[1], f[2], f[3], f[4], yy, 0);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
